// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x oversampling UART receiver (start, 8 data LSB first,
// optional parity, one stop bit). Companion of the TxUnit transmitter and
// uses the same parity_type / baud_rate encodings.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   data_rx      serial input, idle high, asynchronous to clock
//   parity_type  01 odd, 10 even, 00/11 no parity bit
//   baud_rate    00 2400, 01 4800, 10 19200, 11 9600 baud
//   data_out     last received byte
//   done_flag    one-cycle pulse when a frame completes (good or bad)
//   active_flag  high while a frame is being received
//   parity_error parity mismatch in the last frame
//   frame_error  stop bit sampled low in the last frame
//   baud_clk_w   one-cycle oversample tick
module uart_rx_unit #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       done_flag,
    output logic       active_flag,
    output logic       parity_error,
    output logic       frame_error,
    output logic       baud_clk_w
);

    localparam int unsigned DIV_2400  = CLK_FREQ / (2400 * OVERSAMPLE);
    localparam int unsigned DIV_4800  = CLK_FREQ / (4800 * OVERSAMPLE);
    localparam int unsigned DIV_9600  = CLK_FREQ / (9600 * OVERSAMPLE);
    localparam int unsigned DIV_19200 = CLK_FREQ / (19200 * OVERSAMPLE);

    localparam logic [15:0] LAST_2400  = 16'(DIV_2400 - 1);
    localparam logic [15:0] LAST_4800  = 16'(DIV_4800 - 1);
    localparam logic [15:0] LAST_9600  = 16'(DIV_9600 - 1);
    localparam logic [15:0] LAST_19200 = 16'(DIV_19200 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sync1;
    logic        rx_s;
    logic        rx_prev;
    logic [1:0]  baud_l;
    logic [1:0]  par_l;
    logic [15:0] div_cnt;
    logic [15:0] div_last;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic        par_err_pend;

    logic        fall_c;
    logic        mid7_c;
    logic        mid15_c;
    logic        par_on_c;
    logic        par_bad_c;
    logic        start_c;
    logic        go_data_c;
    logic        shift_c;
    logic        par_c;
    logic        stop_c;

    // Two-flop synchroniser plus previous-sample flop for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= data_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign fall_c   = rx_prev & ~rx_s;
    assign mid7_c   = baud_clk_w && (tick_cnt == 4'd7);
    assign mid15_c  = baud_clk_w && (tick_cnt == 4'd15);
    assign par_on_c = par_l[0] ^ par_l[1];
    // Even: sample must equal XOR of data; odd: its inverse.
    assign par_bad_c = rx_s != ((^shift_q) ^ (par_l == 2'b01));

    // Divider terminal count for the latched baud selection.
    always_comb begin
        div_last = LAST_9600;
        case (baud_l)
            2'b00:   div_last = LAST_2400;
            2'b01:   div_last = LAST_4800;
            2'b10:   div_last = LAST_19200;
            default: div_last = LAST_9600;
        endcase
    end

    // Settings track the inputs while idle and freeze from the start edge on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_l <= 2'b00;
            par_l  <= 2'b00;
        end else if (state == S_IDLE) begin
            baud_l <= baud_rate;
            par_l  <= parity_type;
        end
    end

    // Free-running tick divider; restarted on the start edge to align phase.
    // ">=" recovers cleanly if the divisor shrinks while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= 16'd0;
            baud_clk_w <= 1'b0;
        end else if (start_c) begin
            div_cnt    <= 16'd0;
            baud_clk_w <= 1'b0;
        end else if (div_cnt >= div_last) begin
            div_cnt    <= 16'd0;
            baud_clk_w <= 1'b1;
        end else begin
            div_cnt    <= div_cnt + 16'd1;
            baud_clk_w <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        go_data_c = 1'b0;
        shift_c   = 1'b0;
        par_c     = 1'b0;
        stop_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_c) begin
                    state_nxt = S_START;
                    start_c   = 1'b1;
                end
            end
            S_START: begin
                if (mid7_c) begin
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DATA;
                        go_data_c = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (mid15_c) begin
                    shift_c = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = par_on_c ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (mid15_c) begin
                    par_c     = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (mid15_c) begin
                    stop_c    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit-level counters, shift register and pending parity result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt     <= 4'd0;
            bit_idx      <= 3'd0;
            shift_q      <= 8'd0;
            par_err_pend <= 1'b0;
        end else begin
            if (start_c || go_data_c) begin
                tick_cnt <= 4'd0;
            end else if (baud_clk_w && (state != S_IDLE)) begin
                tick_cnt <= tick_cnt + 4'd1;
            end

            if (go_data_c) begin
                bit_idx <= 3'd0;
            end else if (shift_c) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (shift_c) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end

            if (go_data_c) begin
                par_err_pend <= 1'b0;
            end else if (par_c) begin
                par_err_pend <= par_bad_c;
            end
        end
    end

    // Host-facing outputs; error flags clear on the next valid start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= 8'd0;
            done_flag    <= 1'b0;
            active_flag  <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            done_flag   <= stop_c;
            active_flag <= (state_nxt != S_IDLE);
            if (stop_c) begin
                data_out     <= shift_q;
                parity_error <= par_err_pend;
                frame_error  <= ~rx_s;
            end else if (go_data_c) begin
                parity_error <= 1'b0;
                frame_error  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: frames are driven bit by bit, expected results are
// queued at send time and popped when done_flag pulses.
module tb_uart_rx_unit;

    localparam int unsigned CLK_FREQ = 768_000;
    localparam int B2400  = 16 * int'(CLK_FREQ / (2400 * 16));
    localparam int B4800  = 16 * int'(CLK_FREQ / (4800 * 16));
    localparam int B9600  = 16 * int'(CLK_FREQ / (9600 * 16));
    localparam int B19200 = 16 * int'(CLK_FREQ / (19200 * 16));

    logic       clock       = 1'b0;
    logic       reset_n     = 1'b0;
    logic       data_rx     = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate   = 2'b11;
    logic [7:0] data_out;
    logic       done_flag;
    logic       active_flag;
    logic       parity_error;
    logic       frame_error;
    logic       baud_clk_w;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;
    bit active_seen = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;

    uart_rx_unit #(
        .CLK_FREQ  (CLK_FREQ),
        .OVERSAMPLE(16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_rx     (data_rx),
        .parity_type (parity_type),
        .baud_rate   (baud_rate),
        .data_out    (data_out),
        .done_flag   (done_flag),
        .active_flag (active_flag),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .baud_clk_w  (baud_clk_w)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit par_of(input logic [7:0] d, input bit odd);
        return odd ? ~^d : ^d;
    endfunction

    task automatic push_exp(input logic [7:0] d, input bit perr, input bit ferr);
        exp_q.push_back({ferr, perr, d});
    endtask

    task automatic send_frame(input logic [7:0] d, input int bc, input bit has_par,
                              input bit pbit, input bit stop);
        @(negedge clock);
        start_cyc = cyc;
        data_rx = 1'b0;
        repeat (bc) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            data_rx = d[i];
            repeat (bc) @(negedge clock);
        end
        if (has_par) begin
            data_rx = pbit;
            repeat (bc) @(negedge clock);
        end
        data_rx = stop;
        repeat (bc) @(negedge clock);
        data_rx = 1'b1;
    endtask

    // Scoreboard: every done_flag must match the oldest queued frame.
    always @(negedge clock) begin
        if (active_flag) active_seen = 1'b1;
        if (done_flag) begin
            done_cnt++;
            last_done_cyc = cyc;
            chk("frame_pending_at_done", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e[7:0]));
                chk("parity_error", 32'(parity_error), 32'(mon_e[8]));
                chk("frame_error", 32'(frame_error), 32'(mon_e[9]));
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("FAIL watchdog: cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int first;
        int second;
        int lat;
        logic [7:0] d;

        // Reset state
        repeat (5) @(negedge clock);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_done", 32'(done_flag), 0);
        chk("rst_active", 32'(active_flag), 0);
        chk("rst_perr", 32'(parity_error), 0);
        chk("rst_ferr", 32'(frame_error), 0);
        chk("rst_tick", 32'(baud_clk_w), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Oversample tick period at 9600 (divider 5)
        first = -1;
        second = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (baud_clk_w) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        chk("tick_period_9600", 32'(second - first), 5);

        // 9600, no parity, 0xA5, with stop-bit-centre latency check
        dc = done_cnt;
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, B9600, 1'b0, 1'b0, 1'b1);
        chk("t1_done_count", 32'(done_cnt), 32'(dc + 1));
        lat = last_done_cyc - start_cyc;
        chk("t1_latency_window", 32'(lat >= (17 * B9600) / 2 && lat <= (21 * B9600) / 2), 1);

        // Odd parity, good then bad parity bit
        parity_type = 2'b01;
        dc = done_cnt;
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, B9600, 1'b1, par_of(8'h3C, 1'b1), 1'b1);
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, B9600, 1'b1, ~par_of(8'h3C, 1'b1), 1'b1);
        chk("t2_done_count", 32'(done_cnt), 32'(dc + 2));

        // Even parity, stop bit low; flag holds until the next valid start
        parity_type = 2'b10;
        push_exp(8'h7E, 1'b0, 1'b1);
        send_frame(8'h7E, B9600, 1'b1, par_of(8'h7E, 1'b0), 1'b0);
        repeat (B9600) @(negedge clock);
        chk("t3_ferr_held_idle", 32'(frame_error), 1);
        push_exp(8'h81, 1'b0, 1'b0);
        fork
            send_frame(8'h81, B9600, 1'b1, par_of(8'h81, 1'b0), 1'b1);
            begin
                repeat (B9600 / 4) @(negedge clock);
                chk("t3_ferr_before_start_mid", 32'(frame_error), 1);
                repeat (B9600) @(negedge clock);
                chk("t3_ferr_cleared", 32'(frame_error), 0);
            end
        join

        // Glitch shorter than half a bit
        dc = done_cnt;
        @(negedge clock);
        active_seen = 1'b0;
        data_rx = 1'b0;
        repeat (3 * (B9600 / 16)) @(negedge clock);
        data_rx = 1'b1;
        repeat (2 * B9600) @(negedge clock);
        chk("t4_active_seen", 32'(active_seen), 1);
        chk("t4_active_now", 32'(active_flag), 0);
        chk("t4_no_done", 32'(done_cnt), 32'(dc));

        // Reset in the middle of data bit 4 of 0x55
        parity_type = 2'b00;
        d = 8'h55;
        dc = done_cnt;
        @(negedge clock);
        data_rx = 1'b0;
        repeat (B9600) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            data_rx = d[i];
            repeat (B9600) @(negedge clock);
        end
        data_rx = d[4];
        repeat (B9600 / 2) @(negedge clock);
        chk("t5_active_before_rst", 32'(active_flag), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_data_out", 32'(data_out), 0);
        chk("t5_rst_active", 32'(active_flag), 0);
        chk("t5_rst_done", 32'(done_flag), 0);
        chk("t5_rst_perr", 32'(parity_error), 0);
        chk("t5_rst_ferr", 32'(frame_error), 0);
        chk("t5_rst_tick", 32'(baud_clk_w), 0);
        data_rx = 1'b1;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (B9600) @(negedge clock);
        chk("t5_no_done", 32'(done_cnt), 32'(dc));
        push_exp(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, B9600, 1'b0, 1'b0, 1'b1);

        // Back-to-back 2400 frames; baud input changed mid-frame
        baud_rate = 2'b00;
        dc = done_cnt;
        push_exp(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, B2400, 1'b0, 1'b0, 1'b1);
        push_exp(8'hFF, 1'b0, 1'b0);
        fork
            send_frame(8'hFF, B2400, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 * B2400) @(negedge clock);
                baud_rate = 2'b11;
            end
        join
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, B9600, 1'b0, 1'b0, 1'b1);
        chk("t6_done_count", 32'(done_cnt), 32'(dc + 3));

        // A few random bytes at 19200 with even parity
        baud_rate = 2'b10;
        parity_type = 2'b10;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            push_exp(d, 1'b0, 1'b0);
            send_frame(d, B19200, 1'b1, par_of(d, 1'b0), 1'b1);
        end

        // 4800 with parity_type 11: no parity bit expected
        baud_rate = 2'b01;
        parity_type = 2'b11;
        push_exp(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, B4800, 1'b0, 1'b0, 1'b1);

        repeat (20) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
